synthesijer_fconv_f2i_pipe: RTL and testbench
=============================================

// Module: synthesijer_fconv_f2i_pipe
// PURPOSE
//  Native-RTL, parametrised float->signed-integer converter; vendor-IP-free successor to the f2i wrapper.
//  Serves as the HLS back end for Java (int)/(long) casts from float/double, plus a round-to-nearest mode.
//  Fixed-latency 3-stage pipeline. nd/valid stream, no backpressure. Accepts one operand per cycle.
// PARAMETERS
//  EXP_W      8   exponent field width (11 for double)
//  MAN_W      23  stored mantissa width (52 for double)
//  INT_W      32  result integer width (64 for long)
//  ROUND_MODE 0   0 = truncate toward zero (Java cast), 1 = round nearest, ties to even
// PORTS
//  clk      in  1                 rising-edge clock
//  reset    in  1                 asynchronous, active-low reset
//  a        in  1+EXP_W+MAN_W     IEEE-754 operand {sign, exp, man}
//  nd       in  1                 operand valid; sampled every clk edge
//  result   out INT_W (signed)    converted integer, registered
//  valid    out 1                 result/flags valid, exactly 3 cycles after nd
//  inexact  out 1                 fractional bits discarded (non-zero fraction)
//  overflow out 1                 |value| outside INT_W range, or +/-inf; result saturated
//  invalid  out 1                 operand was NaN; result = 0
// BEHAVIOUR
//  - Reset (reset=0, async): valid, result, inexact, overflow, invalid and all stage-valid regs go to 0
//    immediately. Ops in flight are discarded; none emerge after release.
//  - Latency 3: nd at edge N -> valid=1 with result at edge N+3. valid is a pure 3-deep shift of nd.
//    Data regs load only when their stage valid is 1 and otherwise hold. Flags update with result.
//  - S1 decode: s, e, m. BIAS = 2**(EXP_W-1)-1. E = e - BIAS, signed EXP_W+1 bits.
//    Classes: zero/denormal (e==0), NaN (e=all-ones, m!=0), inf (e=all-ones, m==0), normal.
//  - S2 align: sig = {1'b1,m}. If E >= MAN_W: mag = sig << (E-MAN_W), shift clamped at INT_W.
//    Else right-shift by MAN_W-E, giving guard bit g (first dropped) and sticky st (OR of rest).
//    Shift clamp at MAN_W+2: then g=0 and st=1. Magnitude reg is INT_W+1 bits wide.
//  - S3 round/sign/saturate:
//    mode 0: r = mag.
//    mode 1: r = mag + (g & (st | mag[0])).
//    inexact = g | st. Zero/denormal input: r = 0, inexact = (m != 0).
//    Result = s ? -r : r.
//  - Range: MAX = 2**(INT_W-1)-1, MIN = -2**(INT_W-1). Checked after rounding.
//    s=0 and r > MAX -> MAX, overflow=1. s=1 and r > 2**(INT_W-1) -> MIN, overflow=1.
//    s=1 and r == 2**(INT_W-1) -> MIN, overflow=0.
//    +inf -> MAX, -inf -> MIN, overflow=1, inexact=0. NaN -> 0, invalid=1, other flags 0.
//  - -0.0 -> 0, no flags. Mode 0 with E<0 -> 0, inexact=1.
//  - Back-to-back nd every cycle fully supported. Gaps in nd produce matching gaps in valid.
// STRUCTURE
//  - Package synthesijer_fp_pkg: RND_TRUNC/RND_RNE encodings, fp32/fp64 EXP_W/MAN_W/BIAS constants,
//    fp class enum (FP_ZERO, FP_NORM, FP_INF, FP_NAN).
//  - Sub-module synthesijer_fp_unpack (combinational, parametrised by EXP_W/MAN_W): sign, unbiased exp,
//    sig with hidden bit, class. Reused later by the i2f/f2f converters.
//  - Top: three pipeline register banks. Align shifter and round/saturate logic inline.
// TESTING (defaults unless noted; check each case at nd+3)
//  1. 0x3FC00000 (1.5): mode 0 -> 1, inexact=1. Mode 1 -> 2.
//     0x40200000 (2.5), mode 1 -> 2 (tie to even). 0xC0200000 (-2.5), mode 0 -> -2.
//  2. 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1.
//     0xCF000000 (-2^31) -> 0x80000000, overflow=0.
//     Mode 1, 0x4EFFFFFF (2147483520) -> 2147483520, exact.
//  3. 0x7FC00000 NaN -> 0, invalid=1. 0xFF800000 (-inf) -> 0x80000000, overflow=1.
//     0x00000001 denormal -> 0, inexact=1. 0x80000000 (-0.0) -> 0, no flags.
//  4. Stream 16 ops with nd=1,1,0,1,... -> valid pattern equals nd delayed 3. Results in order.
//     Compare each against a reference model (Java cast semantics).
//  5. Drop reset low for 1 cycle while 3 ops are in flight -> valid=0 at once, outputs 0.
//     No valid is seen until the next nd+3.
//  6. EXP_W=11, MAN_W=52, INT_W=64: 0x43E0000000000000 (2^63) -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1.
//     0xC00C000000000000 (-3.5), mode 1 -> -4.

Source files
------------

// File: rtl/synthesijer_fp_pkg.sv
// Shared floating-point definitions for the synthesijer converter family.
// Rounding-mode encodings, IEEE-754 format constants and the operand class enum.
package synthesijer_fp_pkg;

    localparam int RND_TRUNC = 0;
    localparam int RND_RNE   = 1;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    localparam int FP64_EXP_W = 11;
    localparam int FP64_MAN_W = 52;
    localparam int FP64_BIAS  = 1023;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_t;

endpackage

// File: rtl/synthesijer_fp_unpack.sv
// Combinational IEEE-754 field decoder: sign, unbiased exponent, significand with
// hidden bit, and operand class. Denormals are reported as FP_ZERO.
module synthesijer_fp_unpack
    import synthesijer_fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    a_word_unused_guard,
    input  logic [EXP_W+MAN_W:0]    a,
    output logic                    sign,
    output logic signed [EXP_W:0]   exp_unb,
    output logic [MAN_W:0]          sig,
    output fp_class_t               fclass
);

    localparam logic [EXP_W:0] BIAS = {2'b00, {(EXP_W-1){1'b1}}};

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             tie_off;

    assign tie_off = a_word_unused_guard;
    assign sign    = a[EXP_W+MAN_W];
    assign e       = a[EXP_W+MAN_W-1:MAN_W];
    assign m       = a[MAN_W-1:0];
    assign exp_unb = $signed({1'b0, e} - BIAS);
    assign sig     = {(e != '0), m};

    always_comb begin
        fclass = FP_NORM;
        if (e == '0) begin
            fclass = FP_ZERO;
        end else if (&e) begin
            fclass = (m != '0) ? FP_NAN : FP_INF;
        end
    end

endmodule

// File: rtl/synthesijer_fconv_f2i_pipe.sv
// Three-stage float -> signed integer converter (decode, align, round/saturate).
// Truncation matches Java (int)/(long) casts; ROUND_MODE=1 rounds to nearest even.
module synthesijer_fconv_f2i_pipe
    import synthesijer_fp_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int INT_W      = 32,
    parameter int ROUND_MODE = RND_TRUNC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic                     nd,
    output logic signed [INT_W-1:0]  result,
    output logic                     valid,
    output logic                     inexact,
    output logic                     overflow,
    output logic                     invalid
);

    localparam int SH_W   = EXP_W + 2;
    localparam int WIDE_W = INT_W + MAN_W + 2;
    localparam int EXT_W  = 2 * MAN_W + 3;
    localparam logic signed [SH_W-1:0] MAN_S    = SH_W'(MAN_W);
    localparam logic signed [SH_W-1:0] INT_S    = SH_W'(INT_W);
    localparam logic signed [SH_W-1:0] RCLAMP_S = SH_W'(MAN_W + 2);
    localparam logic [INT_W+1:0]       HALF     = (INT_W+2)'(1) << (INT_W - 1);
    localparam logic [INT_W-1:0]       MAX_V    = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0]       MIN_V    = {1'b1, {(INT_W-1){1'b0}}};

    // Anything that does not fit INT_W+1 bits pins to all-ones so the range check still trips.
    function automatic logic [INT_W:0] sat_mag(input logic [WIDE_W-1:0] w);
        if (|w[WIDE_W-1:INT_W+1]) return '1;
        return w[INT_W:0];
    endfunction

    function automatic logic [INT_W+1:0] round_mag(input logic [INT_W:0] mag,
                                                   input logic g, input logic st);
        if (ROUND_MODE == RND_RNE) return {1'b0, mag} + (INT_W+2)'(g & (st | mag[0]));
        return {1'b0, mag};
    endfunction

    // Returns {overflow, value}; a negative magnitude of exactly 2**(INT_W-1) is representable.
    function automatic logic [INT_W:0] saturate(input logic s, input logic [INT_W+1:0] r);
        if (!s && r >= HALF) return {1'b1, MAX_V};
        if (s && r > HALF)   return {1'b1, MIN_V};
        if (s)               return {1'b0, -r[INT_W-1:0]};
        return {1'b0, r[INT_W-1:0]};
    endfunction

    logic                   u_sign;
    logic signed [EXP_W:0]  u_exp;
    logic [MAN_W:0]         u_sig;
    fp_class_t              u_cls;

    synthesijer_fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack (
        .a_word_unused_guard (1'b0),
        .a                   (a),
        .sign                (u_sign),
        .exp_unb             (u_exp),
        .sig                 (u_sig),
        .fclass              (u_cls)
    );

    logic vld_p1, vld_p2, vld_p3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p1 <= nd;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    assign valid = vld_p3;

    // ---- stage 1: decoded operand ----
    logic                   sign_p1;
    logic signed [EXP_W:0]  exp_p1;
    logic [MAN_W:0]         sig_p1;
    fp_class_t              cls_p1;

    always_ff @(posedge clk) begin
        if (nd) begin
            sign_p1 <= u_sign;
            exp_p1  <= u_exp;
            sig_p1  <= u_sig;
            cls_p1  <= u_cls;
        end
    end

    logic signed [SH_W-1:0] e_ext, lsh, rsh;
    logic [SH_W-1:0]        lsh_amt, rsh_amt;
    logic [WIDE_W-1:0]      wide;
    logic [EXT_W-1:0]       ext;
    logic [INT_W:0]         mag_c;
    logic                   g_c, st_c;

    always_comb begin
        e_ext   = SH_W'(exp_p1);
        lsh     = e_ext - MAN_S;
        rsh     = MAN_S - e_ext;
        lsh_amt = '0;
        rsh_amt = '0;
        wide    = '0;
        ext     = '0;
        g_c     = 1'b0;
        st_c    = 1'b0;
        if (!lsh[SH_W-1]) begin
            lsh_amt = (lsh >= INT_S) ? INT_S : lsh;
            wide    = WIDE_W'(sig_p1) << lsh_amt;
        end else if (rsh >= RCLAMP_S) begin
            st_c = 1'b1;
        end else begin
            // MAN_W+2 zero bits below the significand catch guard and sticky after the shift.
            rsh_amt = rsh;
            ext     = {sig_p1, {(MAN_W+2){1'b0}}} >> rsh_amt;
            wide    = WIDE_W'(ext[EXT_W-1:MAN_W+2]);
            g_c     = ext[MAN_W+1];
            st_c    = |ext[MAN_W:0];
        end
        mag_c = sat_mag(wide);
    end

    // ---- stage 2: aligned magnitude ----
    logic [INT_W:0] mag_p2;
    logic           g_p2, st_p2, sign_p2, mnz_p2;
    fp_class_t      cls_p2;

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            mag_p2  <= mag_c;
            g_p2    <= g_c;
            st_p2   <= st_c;
            sign_p2 <= sign_p1;
            mnz_p2  <= |sig_p1[MAN_W-1:0];
            cls_p2  <= cls_p1;
        end
    end

    logic [INT_W+1:0] r_c;
    logic [INT_W:0]   sat_c;
    logic [INT_W-1:0] res_c;
    logic             inx_c, ovf_c, inv_c;

    always_comb begin
        r_c   = round_mag(mag_p2, g_p2, st_p2);
        sat_c = saturate(sign_p2, r_c);
        res_c = sat_c[INT_W-1:0];
        ovf_c = sat_c[INT_W];
        inx_c = g_p2 | st_p2;
        inv_c = 1'b0;
        case (cls_p2)
            FP_ZERO: begin
                res_c = '0;
                ovf_c = 1'b0;
                inx_c = mnz_p2;
            end
            FP_INF: begin
                res_c = sign_p2 ? MIN_V : MAX_V;
                ovf_c = 1'b1;
                inx_c = 1'b0;
            end
            FP_NAN: begin
                res_c = '0;
                ovf_c = 1'b0;
                inx_c = 1'b0;
                inv_c = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- stage 3: registered result and flags ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result   <= '0;
            inexact  <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else if (vld_p2) begin
            result   <= res_c;
            inexact  <= inx_c;
            overflow <= ovf_c;
            invalid  <= inv_c;
        end
    end

endmodule

// File: tb/tb_synthesijer_fconv_f2i_pipe.sv
// Directed bench for the float->int pipeline: fp32 truncate and round-nearest
// instances plus an fp64->int64 round-nearest instance sharing one nd stream.
module tb_synthesijer_fconv_f2i_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        nd;
    logic [31:0] a32;
    logic [63:0] a64;

    logic signed [31:0] res_t, res_r;
    logic signed [63:0] res_d;
    logic vld_t, inx_t, ovf_t, inv_t;
    logic vld_r, inx_r, ovf_r, inv_r;
    logic vld_d, inx_d, ovf_d, inv_d;

    synthesijer_fconv_f2i_pipe #(.ROUND_MODE(0)) u_trunc (
        .clk(clk), .reset(reset), .a(a32), .nd(nd), .result(res_t), .valid(vld_t),
        .inexact(inx_t), .overflow(ovf_t), .invalid(inv_t)
    );

    synthesijer_fconv_f2i_pipe #(.ROUND_MODE(1)) u_rne (
        .clk(clk), .reset(reset), .a(a32), .nd(nd), .result(res_r), .valid(vld_r),
        .inexact(inx_r), .overflow(ovf_r), .invalid(inv_r)
    );

    synthesijer_fconv_f2i_pipe #(.EXP_W(11), .MAN_W(52), .INT_W(64), .ROUND_MODE(1)) u_dbl (
        .clk(clk), .reset(reset), .a(a64), .nd(nd), .result(res_d), .valid(vld_d),
        .inexact(inx_d), .overflow(ovf_d), .invalid(inv_d)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Java (int) cast of an fp32 value, computed through the simulator's real type.
    function automatic logic [31:0] java_f2i(input logic [31:0] f);
        logic [63:0] d;
        real         r;
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'd0) return 32'd0;
            return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        if (f[30:23] == 8'h00) return 32'd0;
        d = {f[31], ({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        r = $bitstoreal(d);
        if (r >= 2147483648.0)  return 32'h7FFF_FFFF;
        if (r <= -2147483648.0) return 32'h8000_0000;
        return $rtoi(r);
    endfunction

    task automatic apply_op(input logic [31:0] v32, input logic [63:0] v64);
        @(posedge clk); #1;
        a32 = v32;
        a64 = v64;
        nd  = 1'b1;
        @(posedge clk); #1;
        nd = 1'b0;
        @(posedge clk); #1;
        chk("no_early_valid", {63'd0, vld_t}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] v,
                           input logic [31:0] rt, input logic [2:0] ft,
                           input logic [31:0] rr, input logic [2:0] fr);
        apply_op(v, 64'd0);
        chk({tag, "_vld"},  {62'd0, vld_t, vld_r}, 64'd3);
        chk({tag, "_t"},    {32'd0, res_t}, {32'd0, rt});
        chk({tag, "_tflg"}, {61'd0, inx_t, ovf_t, inv_t}, {61'd0, ft});
        chk({tag, "_r"},    {32'd0, res_r}, {32'd0, rr});
        chk({tag, "_rflg"}, {61'd0, inx_r, ovf_r, inv_r}, {61'd0, fr});
    endtask

    task automatic check64(input string tag, input logic [63:0] v,
                           input logic [63:0] rd, input logic [2:0] fd);
        apply_op(32'd0, v);
        chk({tag, "_vld"}, {63'd0, vld_d}, 64'd1);
        chk({tag, "_res"}, res_d, rd);
        chk({tag, "_flg"}, {61'd0, inx_d, ovf_d, inv_d}, {61'd0, fd});
    endtask

    logic [15:0] pat;
    logic [31:0] ops [16];

    initial begin
        pat = 16'b1101_0111_1001_1011;
        ops = '{32'h3FC00000, 32'hBFC00000, 32'h42C9CCCD, 32'hBE99999A,
                32'h4CEB79A3, 32'h4F32D05E, 32'hCF32D05E, 32'h7FC00000,
                32'hFF800000, 32'h00400000, 32'h477FFF80, 32'hBF800000,
                32'h4EFFFFFF, 32'hCF000000, 32'h3F7FFFFF, 32'h40FFAE14};

        reset = 1'b1;
        nd    = 1'b0;
        a32   = '0;
        a64   = '0;
        #2 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid",  {61'd0, vld_t, vld_r, vld_d}, 64'd0);
        chk("rst_res_t",  {32'd0, res_t}, 64'd0);
        chk("rst_res_d",  res_d, 64'd0);
        chk("rst_flags",  {61'd0, inx_t | inx_d, ovf_t | ovf_d, inv_t | inv_d}, 64'd0);
        reset = 1'b1;

        // {inexact, overflow, invalid}
        check32("p1_5",     32'h3FC00000, 32'h00000001, 3'b100, 32'h00000002, 3'b100);
        check32("p2_5",     32'h40200000, 32'h00000002, 3'b100, 32'h00000002, 3'b100);
        check32("m2_5",     32'hC0200000, 32'hFFFFFFFE, 3'b100, 32'hFFFFFFFE, 3'b100);
        check32("m3_5",     32'hC0600000, 32'hFFFFFFFD, 3'b100, 32'hFFFFFFFC, 3'b100);
        check32("p0_5",     32'h3F000000, 32'h00000000, 3'b100, 32'h00000000, 3'b100);
        check32("p0_75",    32'h3F400000, 32'h00000000, 3'b100, 32'h00000001, 3'b100);
        check32("p3",       32'h40400000, 32'h00000003, 3'b000, 32'h00000003, 3'b000);
        check32("e23",      32'h4B000001, 32'h00800001, 3'b000, 32'h00800001, 3'b000);
        check32("p2p31",    32'h4F000000, 32'h7FFFFFFF, 3'b010, 32'h7FFFFFFF, 3'b010);
        check32("m2p31",    32'hCF000000, 32'h80000000, 3'b000, 32'h80000000, 3'b000);
        check32("maxflt",   32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 32'h7FFFFF80, 3'b000);
        check32("p1e10",    32'h501502F9, 32'h7FFFFFFF, 3'b010, 32'h7FFFFFFF, 3'b010);
        check32("nan",      32'h7FC00000, 32'h00000000, 3'b001, 32'h00000000, 3'b001);
        check32("pinf",     32'h7F800000, 32'h7FFFFFFF, 3'b010, 32'h7FFFFFFF, 3'b010);
        check32("minf",     32'hFF800000, 32'h80000000, 3'b010, 32'h80000000, 3'b010);
        check32("denorm",   32'h00000001, 32'h00000000, 3'b100, 32'h00000000, 3'b100);
        check32("negzero",  32'h80000000, 32'h00000000, 3'b000, 32'h00000000, 3'b000);

        check64("d2p63",  64'h43E0000000000000, 64'h7FFFFFFFFFFFFFFF, 3'b010);
        check64("dm3_5",  64'hC00C000000000000, 64'hFFFFFFFFFFFFFFFC, 3'b100);
        check64("dm2p63", 64'hC3E0000000000000, 64'h8000000000000000, 3'b000);
        check64("d1_5",   64'h3FF8000000000000, 64'h0000000000000002, 3'b100);

        // Gapped stream: valid must be nd delayed three cycles, results in order.
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
            if (c >= 3) begin
                chk("stream_valid", {63'd0, vld_t}, {63'd0, pat[c-3]});
                if (pat[c-3]) chk("stream_result", {32'd0, res_t}, {32'd0, java_f2i(ops[c-3])});
            end
            if (c < 16) begin
                nd  = pat[c];
                a32 = pat[c] ? ops[c] : 32'hDEADBEEF;
            end else begin
                nd = 1'b0;
            end
        end

        // Reset pulse with operations in flight.
        @(posedge clk); #1;
        a32 = 32'h40400000; nd = 1'b1;
        @(posedge clk); #1;
        a32 = 32'h40800000;
        @(posedge clk); #1;
        a32 = 32'h40A00000;
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", {61'd0, vld_t, vld_r, vld_d}, 64'd0);
        chk("midrst_res_t", {32'd0, res_t}, 64'd0);
        chk("midrst_res_r", {32'd0, res_r}, 64'd0);
        chk("midrst_flags", {61'd0, inx_t | inx_r, ovf_t | ovf_r, inv_t | inv_r}, 64'd0);
        nd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("postrst_quiet", {62'd0, vld_t, vld_r}, 64'd0);
        end
        check32("after_rst", 32'h40E00000, 32'h00000007, 3'b000, 32'h00000007, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
